mac_array_seq: RTL and testbench

- Sequencer for an N x N systolic array of signed 8-bit MAC cells: one tile = clear, skewed feed of K operand pairs, drain of results.
- Drives the array-wide clear/en controls and a feed counter from which the operand buffers derive per-lane skewed read indices.
- Presents accumulated rows to a downstream consumer one row at a time over valid/ready.
- Sits between the tile-dispatch logic (start handshake) and the MAC array plus its operand/result buffers.

---
 rtl/mac_array_seq.sv | 199 +++++++++++++++++++
 tb/tb_mac_array_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq.sv
// ---------------------------------------------------------------------------
// mac_array_seq
// Tile sequencer for an N x N systolic array of signed 8-bit MAC cells.
// One tile: clear the accumulators, feed K skewed operand pairs (plus the
// 2(N-1) cycles of skew fill/flush), then drain N result rows over valid/ready.
//
// Parameters:
//   N   array dimension (rows = cols = lanes), N >= 2
//   KW  width of the K field and of the feed counter
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_valid/ready tile request handshake; k_len sampled on handshake
//   mac_clear, mac_en array-wide clear / accumulate enable (never both high)
//   feed_cnt          feed cycle index t (low KW bits of the internal count)
//   lane_valid        bit i = operand lane i carries valid data this cycle
//   drain_valid/ready result row handshake, drain_row = row being offered
//   busy              high whenever not idle
//   done              one-cycle pulse after the last row is accepted
//
// Optional feature (macro MAC_ARRAY_SEQ_PERF_EN):
//   perf_stall_cnt    32-bit saturating count of DRAIN cycles with
//                     drain_ready low; cleared by rst and on start handshake.
// ---------------------------------------------------------------------------
module mac_array_seq #(
  parameter int unsigned N  = 4,
  parameter int unsigned KW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [KW-1:0]        k_len,
  output logic                 mac_clear,
  output logic                 mac_en,
  output logic [KW-1:0]        feed_cnt,
  output logic [N-1:0]         lane_valid,
  output logic                 drain_valid,
  input  logic                 drain_ready,
  output logic [$clog2(N)-1:0] drain_row,
  output logic                 busy,
`ifdef MAC_ARRAY_SEQ_PERF_EN
  output logic [31:0]          perf_stall_cnt,
`endif
  output logic                 done
);

  localparam int unsigned RW = $clog2(N);
  localparam int unsigned CW = KW + 1;  // feed length L = K + 2(N-1) fits here
  localparam int unsigned XW = KW + 2;  // lane window compare (i + K) fits here

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;

  logic            start_ready_q, busy_q, mac_clear_q, mac_en_q;
  logic            drain_valid_q, done_q;
  logic [N-1:0]    lane_valid_q, lane_valid_d;

  logic [CW-1:0]   feed_len;
  logic            feed_last;
  logic            start_hs;

  assign start_hs  = start_valid && start_ready_q;
  assign feed_len  = CW'(k_q) + CW'(2 * (N - 1));
  assign feed_last = (cnt_q == feed_len - CW'(1));

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_hs) begin
          k_d     = k_len;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        row_d   = '0;
        state_d = (k_q == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        if (feed_last) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_ready) begin
          if (row_q == RW'(N - 1)) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Lane i is live while t - i indexes inside [0, K); compared wide so that
  // i + K cannot wrap for the largest K.
  always_comb begin
    lane_valid_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lane_valid_d[i] = (state_d == S_FEED)
                     && (XW'(cnt_d) >= XW'(i))
                     && (XW'(cnt_d) <  XW'(i) + XW'(k_d));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Output registers, decoded from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      mac_clear_q   <= 1'b0;
      mac_en_q      <= 1'b0;
      lane_valid_q  <= '0;
      drain_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      start_ready_q <= (state_d == S_IDLE);
      busy_q        <= (state_d != S_IDLE);
      mac_clear_q   <= (state_d == S_CLEAR);
      mac_en_q      <= (state_d == S_FEED);
      lane_valid_q  <= lane_valid_d;
      drain_valid_q <= (state_d == S_DRAIN);
      done_q        <= (state_d == S_DONE);
    end
  end

  // feed_cnt exposes the low KW bits; for the largest K the flush tail wraps,
  // and the buffers' modulo-2^KW (feed_cnt - i) still yields the right index.
  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign mac_clear   = mac_clear_q;
  assign mac_en      = mac_en_q;
  assign feed_cnt    = cnt_q[KW-1:0];
  assign lane_valid  = lane_valid_q;
  assign drain_valid = drain_valid_q;
  assign drain_row   = row_q;
  assign done        = done_q;

`ifdef MAC_ARRAY_SEQ_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of back-pressured drain cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_hs) begin
      stall_q <= '0;
    end else if ((state_q == S_DRAIN) && !drain_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_array_seq.sv
module tb_mac_array_seq;

  localparam int unsigned N  = 4;
  localparam int unsigned KW = 16;

  logic          clk;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [KW-1:0] k_len;
  logic          mac_clear;
  logic          mac_en;
  logic [KW-1:0] feed_cnt;
  logic [N-1:0]  lane_valid;
  logic          drain_valid;
  logic          drain_ready;
  logic [1:0]    drain_row;
  logic          busy;
  logic          done;
`ifdef MAC_ARRAY_SEQ_PERF_EN
  logic [31:0]   perf_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  mac_array_seq #(.N(N), .KW(KW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .k_len          (k_len),
    .mac_clear      (mac_clear),
    .mac_en         (mac_en),
    .feed_cnt       (feed_cnt),
    .lane_valid     (lane_valid),
    .drain_valid    (drain_valid),
    .drain_ready    (drain_ready),
    .drain_row      (drain_row),
    .busy           (busy),
`ifdef MAC_ARRAY_SEQ_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hand-computed K=3 tile, drain_ready held high
  typedef struct {
    int       cyc;
    bit       clr;
    bit       en;
    int       fc;
    bit [3:0] lv;
    bit       dv;
    int       row;
    bit       dn;
    bit       sr;
    bit       bsy;
  } vec_t;

  vec_t tbl[17];

  // Runs one tile from IDLE; expected values come from the cycle-level
  // latency description with drain stalls of sn cycles on row srow.
  task automatic run_tile(input string tag, input int k, input int srow,
                          input int sn, input bit kchg, input bit detail);
    int L, D, dn_c, en_n, l0_n, l3_n, ovl, off, erow;
    bit e_clr, e_en, e_dv;
    logic [KW-1:0] e_fc;
    logic [3:0] e_lv;
    L    = (k == 0) ? 0 : k + 2 * (N - 1);
    D    = L + 2;
    dn_c = D + N + sn;
    en_n = 0; l0_n = 0; l3_n = 0; ovl = 0;
    start_valid = 1'b1;
    k_len       = KW'(k);
    drain_ready = 1'b1;
    for (int c = 0; c <= dn_c + 1; c++) begin
      if (c > 0) begin
        start_valid = kchg && (c < dn_c);
        k_len       = kchg ? KW'(7) : KW'(k);
      end
      e_clr = (c == 1);
      e_en  = (c >= 2) && (c <= L + 1);
      e_fc  = KW'(c - 2);
      for (int i = 0; i < 4; i++)
        e_lv[i] = e_en && (c - 2 >= i) && (c - 2 < i + k);
      e_dv = (c >= D) && (c < dn_c);
      off  = c - D;
      erow = 0;
      drain_ready = 1'b1;
      if (e_dv) begin
        if (off < srow) erow = off;
        else if (off <= srow + sn) erow = srow;
        else erow = off - sn;
        drain_ready = !((off >= srow) && (off < srow + sn));
      end
      if (detail) begin
        chk($sformatf("%s c%0d mac_clear", tag, c), mac_clear, e_clr);
        chk($sformatf("%s c%0d mac_en", tag, c), mac_en, e_en);
        chk($sformatf("%s c%0d lane_valid", tag, c), lane_valid, e_lv);
        chk($sformatf("%s c%0d drain_valid", tag, c), drain_valid, e_dv);
        chk($sformatf("%s c%0d busy", tag, c), busy, (c >= 1) && (c <= dn_c));
        chk($sformatf("%s c%0d start_ready", tag, c), start_ready,
            (c == 0) || (c > dn_c));
        chk($sformatf("%s c%0d done", tag, c), done, c == dn_c);
        if (e_en) chk($sformatf("%s c%0d feed_cnt", tag, c), feed_cnt, e_fc);
        if (e_dv) chk($sformatf("%s c%0d drain_row", tag, c), drain_row, erow);
      end else begin
        if (c == dn_c) chk($sformatf("%s done", tag), done, 1);
        if (c == dn_c + 1) chk($sformatf("%s start_ready", tag), start_ready, 1);
      end
      if (mac_en) en_n++;
      if (lane_valid[0]) l0_n++;
      if (lane_valid[3]) l3_n++;
      if (mac_en && mac_clear) ovl++;
      step();
    end
    chk({tag, " mac_en cycles"}, en_n, L);
    chk({tag, " lane0 cycles"}, l0_n, k);
    chk({tag, " lane3 cycles"}, l3_n, k);
    chk({tag, " clear/en overlap"}, ovl, 0);
`ifdef MAC_ARRAY_SEQ_PERF_EN
    chk({tag, " perf_stall_cnt"}, perf_stall_cnt, sn);
`endif
  endtask

  initial begin
    tbl[0]  = '{0,  0, 0, 0, 4'b0000, 0, 0, 0, 1, 0};
    tbl[1]  = '{1,  1, 0, 0, 4'b0000, 0, 0, 0, 0, 1};
    tbl[2]  = '{2,  0, 1, 0, 4'b0001, 0, 0, 0, 0, 1};
    tbl[3]  = '{3,  0, 1, 1, 4'b0011, 0, 0, 0, 0, 1};
    tbl[4]  = '{4,  0, 1, 2, 4'b0111, 0, 0, 0, 0, 1};
    tbl[5]  = '{5,  0, 1, 3, 4'b1110, 0, 0, 0, 0, 1};
    tbl[6]  = '{6,  0, 1, 4, 4'b1100, 0, 0, 0, 0, 1};
    tbl[7]  = '{7,  0, 1, 5, 4'b1000, 0, 0, 0, 0, 1};
    tbl[8]  = '{8,  0, 1, 6, 4'b0000, 0, 0, 0, 0, 1};
    tbl[9]  = '{9,  0, 1, 7, 4'b0000, 0, 0, 0, 0, 1};
    tbl[10] = '{10, 0, 1, 8, 4'b0000, 0, 0, 0, 0, 1};
    tbl[11] = '{11, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 1};
    tbl[12] = '{12, 0, 0, 0, 4'b0000, 1, 1, 0, 0, 1};
    tbl[13] = '{13, 0, 0, 0, 4'b0000, 1, 2, 0, 0, 1};
    tbl[14] = '{14, 0, 0, 0, 4'b0000, 1, 3, 0, 0, 1};
    tbl[15] = '{15, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 1};
    tbl[16] = '{16, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0};

    rst = 1'b1; start_valid = 1'b0; k_len = '0; drain_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset start_ready", start_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset mac_clear", mac_clear, 0);
    chk("reset mac_en", mac_en, 0);
    chk("reset feed_cnt", feed_cnt, 0);
    chk("reset lane_valid", lane_valid, 0);
    chk("reset drain_valid", drain_valid, 0);
    chk("reset drain_row", drain_row, 0);
    chk("reset done", done, 0);
    rst = 1'b0;
    step();

    // Table-driven nominal tile
    start_valid = 1'b1; k_len = KW'(3); drain_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) start_valid = 1'b0;
      chk($sformatf("tbl c%0d mac_clear", tbl[i].cyc), mac_clear, tbl[i].clr);
      chk($sformatf("tbl c%0d mac_en", tbl[i].cyc), mac_en, tbl[i].en);
      chk($sformatf("tbl c%0d lane_valid", tbl[i].cyc), lane_valid, tbl[i].lv);
      chk($sformatf("tbl c%0d drain_valid", tbl[i].cyc), drain_valid, tbl[i].dv);
      chk($sformatf("tbl c%0d done", tbl[i].cyc), done, tbl[i].dn);
      chk($sformatf("tbl c%0d start_ready", tbl[i].cyc), start_ready, tbl[i].sr);
      chk($sformatf("tbl c%0d busy", tbl[i].cyc), busy, tbl[i].bsy);
      if (tbl[i].en) chk($sformatf("tbl c%0d feed_cnt", tbl[i].cyc), feed_cnt, tbl[i].fc);
      if (tbl[i].dv) chk($sformatf("tbl c%0d drain_row", tbl[i].cyc), drain_row, tbl[i].row);
      step();
    end

    // Back-pressure on row 1 for 3 cycles
    run_tile("stall", 3, 1, 3, 1'b0, 1'b1);
    // K=0: clear then straight to drain
    run_tile("k0", 0, 0, 0, 1'b0, 1'b1);
    // start_valid held with a different k_len while busy
    run_tile("kchg", 3, 0, 0, 1'b1, 1'b1);
    run_tile("second", 7, 0, 0, 1'b0, 1'b1);

    // Reset in the middle of FEED
    start_valid = 1'b1; k_len = KW'(3);
    step();
    start_valid = 1'b0;
    repeat (5) step();
    chk("midrst feed_cnt before", feed_cnt, 4);
    chk("midrst mac_en before", mac_en, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst mac_en", mac_en, 0);
    chk("midrst busy", busy, 0);
    chk("midrst start_ready", start_ready, 1);
    chk("midrst done", done, 0);
    chk("midrst lane_valid", lane_valid, 0);
    chk("midrst drain_valid", drain_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("midrst idle%0d done", i), done, 0);
      chk($sformatf("midrst idle%0d busy", i), busy, 0);
    end
    run_tile("after_rst", 2, 0, 0, 1'b0, 1'b1);

    // Largest K: feed length must not wrap
    run_tile("kmax", 65535, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
